// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB initiator.
//   state_t     - FSM states (IDLE, SETUP, ACCESS)
//   SEL_*       - psel encodings for the peripheral slaves
//   APB_DW/AW   - APB data and address widths
//   legal_sel() - true for a one-hot slave select that maps to a real slave
package apb_pkg;

   localparam int unsigned APB_DW = 32;
   localparam int unsigned APB_AW = 32;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_GPIO = 2'b01;
   localparam logic [1:0] SEL_UART = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Only GPIO and UART exist; 00 and 11 select nothing.
   function automatic logic legal_sel(input logic [1:0] sel);
      return (sel == SEL_GPIO) || (sel == SEL_UART);
   endfunction

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: host command/response channel plus APB bus of the initiator.
//   cmd_*  - host command (valid/ready handshake, write, slave, addr, wdata)
//   rsp_*  - one-cycle response strobe with read data and error flag
//   pAdd, pwData, pwr, psel, pen - APB outputs of the initiator
//   prdata, pready               - APB return path from the selected slave
// Modports: master = the initiator, slave = the host/bus environment.
interface apb_master_if;
   import apb_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [1:0]        cmd_slave;
   logic [APB_AW-1:0] cmd_addr;
   logic [APB_DW-1:0] cmd_wdata;

   logic              rsp_valid;
   logic [APB_DW-1:0] rsp_rdata;
   logic              rsp_err;

   logic [APB_AW-1:0] pAdd;
   logic [APB_DW-1:0] pwData;
   logic              pwr;
   logic [1:0]        psel;
   logic              pen;
   logic [APB_DW-1:0] prdata;
   logic              pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, pAdd, pwData, pwr, psel, pen
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, pAdd, pwData, pwr, psel, pen
   );

endinterface

// File: rtl/apb_master.sv
// apb_master: APB initiator driving GPIO/UART slaves from a host command port.
// Runs SETUP then ACCESS (held until pready) and returns a one-cycle response.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - apb_master_if.master (host command/response + APB signals)
// Parameter:
//   TIMEOUT_CYCLES - ACCESS cycles without pready before abort (1..256)
// Optional feature macro: APB_TIMEOUT_EN enables the ACCESS-phase timeout.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   apb_master_if.master bus
);

   // The wait counter is 8 bits wide, so the limit must be 1..256.
   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout_cycles
      $error("apb_master: TIMEOUT_CYCLES must be in 1..256");
   end

   state_t state;

`ifdef APB_TIMEOUT_EN
   // Count of ACCESS cycles already spent waiting; abort when the current
   // cycle would be the TIMEOUT_CYCLES-th one without pready.
   localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt;
`endif

   // FSM with all bus and response outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.cmd_ready <= 1'b1;
         bus.psel      <= SEL_NONE;
         bus.pen       <= 1'b0;
         bus.pwr       <= 1'b0;
         bus.pAdd      <= '0;
         bus.pwData    <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt      <= '0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  if (legal_sel(bus.cmd_slave)) begin
                     bus.pAdd      <= bus.cmd_addr;
                     bus.pwData    <= bus.cmd_wdata;
                     bus.pwr       <= bus.cmd_write;
                     bus.psel      <= bus.cmd_slave;
                     bus.pen       <= 1'b0;
                     bus.cmd_ready <= 1'b0;
                     state         <= SETUP;
                  end else begin
                     // Consume the command without touching the bus.
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_err   <= 1'b1;
                     bus.rsp_rdata <= '0;
                  end
               end
            end
            SETUP: begin
               bus.pen <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            ACCESS: begin
               if (bus.pready) begin
                  bus.psel      <= SEL_NONE;
                  bus.pen       <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  bus.rsp_rdata <= bus.pwr ? '0 : bus.prdata;
                  state         <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else if (wait_cnt == WAIT_LIMIT) begin
                  bus.psel      <= SEL_NONE;
                  bus.pen       <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
                  state         <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
`endif
            end
            default: begin
               bus.psel      <= SEL_NONE;
               bus.pen       <= 1'b0;
               bus.cmd_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed, table-driven bench for apb_master, plus hand-written
// sequences for back-to-back commands and reset during ACCESS.
// Cycle c counts clock edges after the cycle in which the command is presented.
module tb_apb_master;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   apb_master_if bus ();

   apb_master #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  slave;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;     // ACCESS cycles with pready low before pready
      int          exp_lat;   // cycles from presentation to rsp_valid
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NVEC = 7;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      bit    legal;
      int    lat;
      int    pulses;
      string tag;
      legal  = (v.slave == 2'b01) || (v.slave == 2'b10);
      lat    = -1;
      pulses = 0;
      tag    = $sformatf("v%0d", idx);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.wr;
      bus.cmd_slave = v.slave;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.prdata    = v.prdata;
      bus.pready    = 1'b0;
      chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      for (int c = 1; c <= v.exp_lat + 2; c++) begin
         step();
         if (c == 1) bus.cmd_valid = 1'b0;
         bus.pready = (c == 2 + v.waits);
         if (bus.rsp_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = c;
               chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
               chk({tag, ".rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
               chk({tag, ".ready_at_rsp"}, 32'(bus.cmd_ready), 32'd1);
            end
         end
         if (!legal) begin
            chk({tag, ".psel_idle"}, 32'(bus.psel), 32'd0);
            chk({tag, ".pen_idle"}, 32'(bus.pen), 32'd0);
         end else if (c == 1) begin
            chk({tag, ".setup_psel"}, 32'(bus.psel), 32'(v.slave));
            chk({tag, ".setup_pen"}, 32'(bus.pen), 32'd0);
            chk({tag, ".setup_pwr"}, 32'(bus.pwr), 32'(v.wr));
            chk({tag, ".setup_pAdd"}, bus.pAdd, v.addr);
         end else if (c < v.exp_lat) begin
            chk({tag, ".acc_psel"}, 32'(bus.psel), 32'(v.slave));
            chk({tag, ".acc_pen"}, 32'(bus.pen), 32'd1);
            chk({tag, ".acc_pAdd"}, bus.pAdd, v.addr);
            chk({tag, ".acc_pwData"}, bus.pwData, v.wdata);
            chk({tag, ".acc_pwr"}, 32'(bus.pwr), 32'(v.wr));
         end else begin
            chk({tag, ".post_psel"}, 32'(bus.psel), 32'd0);
            chk({tag, ".post_pen"}, 32'(bus.pen), 32'd0);
         end
      end
      chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
      chk({tag, ".pulses"}, 32'(pulses), 32'd1);
   endtask

   // Run-time bound so a stuck DUT cannot hang the bench.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulse_cnt;
      int first_at;
      int second_at;

      //             wr    slave  addr          wdata         prdata        waits lat err   rdata
      vecs[0] = '{1'b1, 2'b10, 32'h0000_0004, 32'h0000_0041, 32'hAAAA_5555, 0,  3, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 2'b01, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 3,  6, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b0, 2'b11, 32'h0000_0020, 32'h1111_1111, 32'h2222_2222, 0,  1, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 2'b00, 32'h0000_0024, 32'h3333_3333, 32'h4444_4444, 0,  1, 1'b1, 32'h0};
      vecs[4] = '{1'b0, 2'b10, 32'h0000_0008, 32'hCAFE_0000, 32'h1234_5678, 0,  3, 1'b0, 32'h1234_5678};
      vecs[5] = '{1'b1, 2'b01, 32'h0000_000C, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 2,  5, 1'b0, 32'h0};
      // pready on the 16th ACCESS cycle: normal completion in both builds.
      vecs[6] = '{1'b0, 2'b01, 32'h0000_0030, 32'h0,         32'h5A5A_A5A5, 15, 18, 1'b0, 32'h5A5A_A5A5};

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_slave = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.prdata    = '0;
      bus.pready    = 1'b0;

      // Reset with a legal command pending: it must be ignored.
      rst_n = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_slave = 2'b01;
      bus.cmd_addr  = 32'h0000_00FF;
      step();
      step();
      chk("rst.psel", 32'(bus.psel), 32'd0);
      chk("rst.pen", 32'(bus.pen), 32'd0);
      chk("rst.pwr", 32'(bus.pwr), 32'd0);
      chk("rst.pAdd", bus.pAdd, 32'd0);
      chk("rst.pwData", bus.pwData, 32'd0);
      chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      step();

      for (int i = 0; i < NVEC; i++) begin
         run_vec(i, vecs[i]);
         step();
      end

      // Long wait: aborts at 16 ACCESS cycles with the timeout, otherwise waits.
      begin
         vec_t lv;
`ifdef APB_TIMEOUT_EN
         lv = '{1'b0, 2'b10, 32'h0000_0040, 32'h0, 32'h7777_7777, 25, 18, 1'b1, 32'h0};
`else
         lv = '{1'b0, 2'b10, 32'h0000_0040, 32'h0, 32'h7777_7777, 25, 28, 1'b0, 32'h7777_7777};
`endif
         run_vec(NVEC, lv);
         bus.pready = 1'b0;
         step();
      end

      // Back-to-back: cmd_valid held high across two commands.
      pulse_cnt = 0;
      first_at  = -1;
      second_at = -1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_slave = 2'b10;
      bus.cmd_addr  = 32'h0000_0100;
      bus.cmd_wdata = 32'h0000_00AA;
      bus.pready    = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         step();
         if (c == 1) begin
            bus.cmd_slave = 2'b01;
            bus.cmd_addr  = 32'h0000_0200;
            bus.cmd_wdata = 32'h0000_00BB;
         end
         if (bus.rsp_valid) begin
            pulse_cnt++;
            if (first_at < 0) first_at = c;
            else if (second_at < 0) second_at = c;
         end
         if (c == 3) chk("b2b.ready_with_rsp", 32'(bus.cmd_ready), 32'd1);
         if (c == 4) begin
            bus.cmd_valid = 1'b0;
            chk("b2b.second_psel", 32'(bus.psel), 32'd1);
            chk("b2b.second_pAdd", bus.pAdd, 32'h0000_0200);
         end
      end
      chk("b2b.pulses", 32'(pulse_cnt), 32'd2);
      chk("b2b.first_at", 32'(first_at), 32'd3);
      chk("b2b.spacing", 32'(second_at - first_at), 32'd3);
      bus.pready = 1'b0;
      step();

      // Reset asserted during ACCESS aborts with no response.
      pulse_cnt = 0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_slave = 2'b01;
      bus.cmd_addr  = 32'h0000_0300;
      step();
      bus.cmd_valid = 1'b0;
      step();
      chk("rstacc.pen", 32'(bus.pen), 32'd1);
      rst_n = 1'b0;
      step();
      if (bus.rsp_valid) pulse_cnt++;
      chk("rstacc.psel", 32'(bus.psel), 32'd0);
      chk("rstacc.pen_low", 32'(bus.pen), 32'd0);
      rst_n = 1'b1;
      bus.pready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         if (bus.rsp_valid) pulse_cnt++;
      end
      chk("rstacc.cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rstacc.no_rsp", 32'(pulse_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB initiator that drives the shared peripheral bus (GPIO and UART slaves) from a simple host command/response interface. It accepts one read or write command at a time and runs the APB SETUP and ACCESS phases, holding ACCESS until pready. It then returns read data, or an error, on a one-cycle response strobe. It sits between the host/CPU-side logic and the psel-decoded peripheral slaves.

Parameters:
TIMEOUT_CYCLES, 16, ACCESS-phase cycles without pready before abort (used only with APB_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  host command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_write  input  1  1 = write, 0 = read
cmd_slave  input  2  target select: 2'b01 GPIO, 2'b10 UART; 2'b00 and 2'b11 are illegal
cmd_addr  input  32  transfer address
cmd_wdata  input  32  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  read data, valid with rsp_valid
rsp_err  output  1  error flag, valid with rsp_valid
pAdd  output  32  APB address
pwData  output  32  APB write data
pwr  output  1  APB write enable
psel  output  2  APB slave select, one-hot or 2'b00
pen  output  1  APB enable
prdata  input  32  APB read data from the selected slave (muxed externally)
pready  input  1  APB slave ready

Behaviour:
- Reset (rst_n low at clk edge): state = IDLE; psel=0, pen=0, pwr=0, pAdd=0, pwData=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-transfer aborts immediately, with no response. cmd_valid is ignored while rst_n is low.
- FSM states: IDLE, SETUP, ACCESS. cmd_ready = (state==IDLE).
- IDLE: on cmd_valid & cmd_ready with a legal cmd_slave:
  - latch cmd_addr into pAdd, cmd_wdata into pwData, cmd_write into pwr, cmd_slave into psel;
  - pen=0; go to SETUP.
- IDLE with an illegal cmd_slave (00/11): command is consumed, no bus activity, stay in IDLE. Next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- SETUP: one cycle exactly. Next state ACCESS with pen=1.
- ACCESS: psel, pAdd, pwData and pwr are held stable. pready is sampled each cycle.
  - pready=1: go to IDLE; psel=0 and pen=0 next cycle. Same edge registers rsp_valid=1, rsp_err=0, and rsp_rdata=prdata for reads or 0 for writes.
  - pready=0: stay in ACCESS (wait states are unbounded without the optional feature).
- rsp_valid is high for exactly one cycle per accepted command.
- pAdd, pwData and pwr keep their last values in IDLE; only psel/pen return to 0.
- Latency: accepted at edge N; SETUP cycle N+1; ACCESS cycle N+2; with zero wait states rsp_valid is high in cycle N+3. cmd_ready is high in that same cycle, so back-to-back throughput is one transfer per 3 cycles.
- Each wait state adds one cycle of latency.
- rsp_valid and a new command acceptance may coincide; both take effect.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: an 8-bit-or-wider counter clears on entering ACCESS and increments each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES, go to IDLE, drop psel/pen, and respond with rsp_valid=1, rsp_err=1, rsp_rdata=0. A pready arriving in the same cycle as the limit wins (normal completion).
- Undefined: no counter, and ACCESS waits indefinitely. rsp_err is asserted only for an illegal cmd_slave.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS);
  - select constants SEL_NONE=2'b00, SEL_GPIO=2'b01, SEL_UART=2'b10;
  - APB_DW=32 and APB_AW=32.
- No sub-module is needed; the FSM and timeout counter stay in one module.

Test Plan:
- Write to UART, cmd_slave=2'b10, addr=0x0000_0004, wdata=0x0000_0041, pready tied 1:
  - SETUP cycle has psel=10, pen=0, pwr=1;
  - ACCESS cycle has pen=1 and pwData=0x41;
  - rsp_valid 3 cycles after acceptance with rsp_err=0.
- Read from GPIO, cmd_slave=2'b01, prdata=0xDEAD_BEEF, pready low for 3 ACCESS cycles: psel/pAdd stay stable, then rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 6 cycles after acceptance.
- Illegal cmd_slave=2'b11: psel and pen stay 0 throughout; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Two back-to-back commands with cmd_valid held high: second command is accepted in the same cycle as the first rsp_valid; exactly two rsp_valid pulses occur, 3 cycles apart.
- rst_n driven low during ACCESS: next cycle psel=0, pen=0, no rsp_valid, cmd_ready=1 after release.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held 0: abort after 16 ACCESS cycles with rsp_err=1. Repeat with pready=1 on cycle 16: normal completion with rsp_err=0.
